// File: rtl/dmem_lsu_if.sv
// Core-side request/response handshake of the load/store unit.
//   master : execute stage (drives req_*, resp_ready)
//   slave  : dmem_lsu      (drives req_ready, resp_*)
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+2:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: initiator side of a synchronous data-memory port.
//   clk, rst_n : clock, async active-low reset
//   core       : request/response handshake (dmem_lsu_if.slave)
//   mem_we, mem_addr, mem_wdata : memory command (word address)
//   mem_rdata  : registered read data, valid the cycle after the address
module dmem_lsu #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_lsu_if.slave         core,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [2:0]          off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                misaligned;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   load_data;
  logic [7:0]          size_mask;
  logic [7:0]          lane_mask;
  logic [DATA_W-1:0]   wd_shift;
  logic [DATA_W-1:0]   merged;

  assign core.req_ready  = (state_q == IDLE);
  assign core.resp_valid = (state_q == RESP);
  assign core.resp_rdata = resp_rdata_q;
  assign core.resp_err   = resp_err_q;
  // Decoded from the async-reset state so a reset during WR drops the strobe at once.
  assign mem_we          = (state_q == WR);
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

  always_comb begin
    misaligned = 1'b0;
    case (core.req_size)
      2'd1:    misaligned = core.req_addr[0];
      2'd2:    misaligned = |core.req_addr[1:0];
      2'd3:    misaligned = |core.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Load alignment/extension and store byte-lane merge, both keyed off the latched request.
  always_comb begin
    rd_shift  = mem_rdata >> {off_q, 3'b000};
    load_data = rd_shift;
    size_mask = 8'hFF;
    case (size_q)
      2'd0: begin
        load_data = {{(DATA_W-8){signed_q & rd_shift[7]}}, rd_shift[7:0]};
        size_mask = 8'h01;
      end
      2'd1: begin
        load_data = {{(DATA_W-16){signed_q & rd_shift[15]}}, rd_shift[15:0]};
        size_mask = 8'h03;
      end
      2'd2: begin
        load_data = {{(DATA_W-32){signed_q & rd_shift[31]}}, rd_shift[31:0]};
        size_mask = 8'h0F;
      end
      default: begin
        load_data = rd_shift;
        size_mask = 8'hFF;
      end
    endcase
    lane_mask = size_mask << off_q;
    wd_shift  = wdata_q << {off_q, 3'b000};
    merged    = mem_rdata;
    for (int unsigned i = 0; i < 8; i++) begin
      if (lane_mask[i]) merged[8*i +: 8] = wd_shift[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          we_d         = core.req_we;
          size_d       = core.req_size;
          signed_d     = core.req_signed;
          off_d        = core.req_addr[2:0];
          wdata_d      = core.req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = misaligned;
          if (misaligned) begin
            state_d = RESP;
          end else begin
            mem_addr_d = core.req_addr[ADDR_W+2:3];
            if (core.req_we && core.req_size == 2'd3) begin
              mem_wdata_d = core.req_wdata;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD:   state_d = WAIT;
      WAIT: begin
        if (we_q) begin
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          resp_rdata_d = load_data;
          state_d      = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: if (core.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
